aes_out_collector: RTL and testbench

- Downstream companion to the unrolled, pipelined MODIFIED_AES128_V1 core.
- Tracks which pipeline slots carry real blocks using a valid delay line matched to the core latency.
- Captures each finished 128-bit ciphertext into a small FIFO and serialises it as 32-bit words on a valid/ready stream.
- Issues credit-based issue_ready to the upstream feeder, so a block is launched into the core only when a FIFO slot is guaranteed on exit.

---
 rtl/aes_out_collector.sv | 240 ++++++++++++++++++++++++
 tb/tb_aes_out_collector.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_out_collector.sv
// -----------------------------------------------------------------------------
// aes_out_collector
//
// Sits downstream of the unrolled, pipelined MODIFIED_AES128_V1 core. A valid
// delay line, matched to the core latency, marks which pipeline slots carry
// real blocks. Finished 128-bit ciphertexts are captured into a small circular
// FIFO and sent out as four 32-bit words on a valid/ready stream, most
// significant word first. The upstream feeder is given credit-based
// issue_ready, so a block only enters the core when a FIFO slot is guaranteed
// for it on exit.
//
// Ports:
//   clk           rising-edge clock shared with the core
//   rst_n         asynchronous active-low reset
//   issue_valid   upstream presents a block to the core this cycle
//   issue_ready   space is guaranteed for a block launched this cycle
//   core_out_data core OUT_DATA, free running
//   m_data        serialised ciphertext word
//   m_valid       m_data valid
//   m_ready       sink accepts m_data
//   m_last        current word is the final (4th) word of a block
//   occupancy     FIFO entries plus blocks still in flight in the core
//   err_overflow  sticky, set when a capture arrives while the FIFO is full
// -----------------------------------------------------------------------------
module aes_out_collector #(
    parameter int PIPE_LAT = 11,
    parameter int DEPTH    = 4,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [127:0]  core_out_data,
    output logic [31:0]   m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [CW-1:0] occupancy,
    output logic          err_overflow
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

    // Pointer increment that wraps at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PTR_LAST) begin
            r = PTR_ZERO;
        end else begin
            r = p + PTR_ONE;
        end
        return r;
    endfunction

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

    logic [PIPE_LAT-1:0] dly_r;
    logic [PIPE_LAT-1:0] dly_nxt_s;
    logic                tap_s;

    logic [127:0]        mem_r [DEPTH];
    logic [PW-1:0]       rd_ptr_r;
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_nxt_s;
    logic [PW-1:0]       wr_ptr_nxt_s;
    logic [CW-1:0]       count_r;
    logic [CW-1:0]       count_nxt_s;
    logic [CW-1:0]       occ_r;
    logic [CW-1:0]       occ_nxt_s;
    logic [1:0]          idx_r;
    logic [1:0]          idx_nxt_s;

    logic                full_s;
    logic                wr_en_s;
    logic                ovf_s;
    logic                issue_fire_s;
    logic                word_fire_s;
    logic                pop_s;

    logic [127:0]        head_nxt_s;
    logic                valid_nxt_s;
    logic                last_nxt_s;
    logic [31:0]         data_nxt_s;

    logic                m_valid_r;
    logic                m_last_r;
    logic [31:0]         m_data_r;
    logic                err_r;

    assign tap_s        = dly_r[PIPE_LAT-1];
    assign issue_ready  = (occ_r < DEPTH_C);
    assign issue_fire_s = issue_valid & issue_ready;
    assign word_fire_s  = m_valid_r & m_ready;
    assign pop_s        = word_fire_s & m_last_r;
    assign full_s       = (count_r == DEPTH_C);

    assign m_valid      = m_valid_r;
    assign m_last       = m_last_r;
    assign m_data       = m_data_r;
    assign occupancy    = occ_r;
    assign err_overflow = err_r;

    // Next-state logic: delay line, credit counter, FIFO pointers and serialiser.
    always_comb begin
        dly_nxt_s    = {PIPE_LAT{1'b0}};
        dly_nxt_s[0] = issue_fire_s;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dly_nxt_s[i] = dly_r[i-1];
        end

        // A pop frees the head on the same edge, so a full FIFO can still take a write then.
        wr_en_s = tap_s & (~full_s | pop_s);
        ovf_s   = tap_s & full_s & ~pop_s;

        if (pop_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        if (wr_en_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // Saturating guards keep the credit count in 0..DEPTH even if the core misbehaves.
        case ({issue_fire_s, pop_s})
            2'b10: begin
                if (occ_r != DEPTH_C) begin
                    occ_nxt_s = occ_r + CNT_ONE;
                end else begin
                    occ_nxt_s = occ_r;
                end
            end
            2'b01: begin
                if (occ_r != CNT_ZERO) begin
                    occ_nxt_s = occ_r - CNT_ONE;
                end else begin
                    occ_nxt_s = occ_r;
                end
            end
            default: occ_nxt_s = occ_r;
        endcase

        if (pop_s) begin
            idx_nxt_s = 2'd0;
        end else if (word_fire_s) begin
            idx_nxt_s = idx_r + 2'd1;
        end else begin
            idx_nxt_s = idx_r;
        end

        // The next head is the incoming block when it lands exactly in the next read slot.
        if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = core_out_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end

        valid_nxt_s = (count_nxt_s != CNT_ZERO);
        if (valid_nxt_s) begin
            data_nxt_s = word_sel(head_nxt_s, idx_nxt_s);
        end else begin
            data_nxt_s = 32'h0000_0000;
        end
        last_nxt_s = valid_nxt_s & (idx_nxt_s == 2'd3);
    end

    // Delay line, credit counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_r <= {PIPE_LAT{1'b0}};
            occ_r <= CNT_ZERO;
            err_r <= 1'b0;
        end else begin
            dly_r <= dly_nxt_s;
            occ_r <= occ_nxt_s;
            err_r <= err_r | ovf_s;
        end
    end

    // FIFO storage, pointers and entry count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 128'h0;
            end
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= core_out_data;
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Registered stream outputs; they only move on a word_fire or when the FIFO fills from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r     <= 2'd0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= 32'h0000_0000;
        end else begin
            idx_r     <= idx_nxt_s;
            m_valid_r <= valid_nxt_s;
            m_last_r  <= last_nxt_s;
            m_data_r  <= data_nxt_s;
        end
    end

endmodule

// File: tb/tb_aes_out_collector.sv
// -----------------------------------------------------------------------------
// Testbench for aes_out_collector. A behavioural core model delays the issued
// data by PIPE_LAT edges; a scoreboard queue receives the four expected words
// of every block accepted by issue_fire and is popped on each word_fire.
// -----------------------------------------------------------------------------
module tb_aes_out_collector;

    localparam int PIPE_LAT = 11;
    localparam int DEPTH    = 4;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_ready;
    logic [127:0]  core_out_data;
    logic [127:0]  issue_data;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [CW-1:0] occupancy;
    logic          err_overflow;

    int n_tests;
    int n_fail;
    int occ_model;

    typedef struct packed {
        logic [31:0] w;
        logic        l;
    } exp_word_t;

    exp_word_t sb[$];

    typedef struct packed {
        logic [127:0]     data;
        logic [0:3][31:0] exp_w;
        int               stall_at;
        int               stall_len;
    } vec_t;

    vec_t vecs [4];

    aes_out_collector #(
        .PIPE_LAT (PIPE_LAT),
        .DEPTH    (DEPTH),
        .CW       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .core_out_data (core_out_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .occupancy     (occupancy),
        .err_overflow  (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: whatever is presented at edge t appears on core_out_data before edge t+PIPE_LAT.
    logic [127:0] core_pipe [PIPE_LAT];
    always @(posedge clk) begin
        core_pipe[0] <= issue_data;
        for (int i = 1; i < PIPE_LAT; i++) begin
            core_pipe[i] <= core_pipe[i-1];
        end
    end
    assign core_out_data = core_pipe[PIPE_LAT-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        issue_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        m_ready     = 1'b1;
        issue_valid = 1'b0;
        while ((m_valid || occupancy != '0) && k < budget) begin
            tick();
            k++;
        end
        chk(name, 128'(m_valid || occupancy != '0), 128'(0));
    endtask

    // Scoreboard monitor, sampled mid-cycle when the inputs for the next edge are stable.
    exp_word_t mon_e;
    int        mon_fire;
    int        mon_pop;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("occupancy_model", 128'(occupancy), 128'(occ_model));
            mon_fire = 0;
            mon_pop  = 0;
            if (issue_valid && issue_ready) begin
                mon_fire = 1;
                for (int k = 0; k < 4; k++) begin
                    sb.push_back('{w: issue_data[127-32*k -: 32], l: (k == 3)});
                end
            end
            if (m_valid && m_ready) begin
                if (m_last) mon_pop = 1;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_word", 128'(m_valid), 128'(0));
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_word", 128'(m_data), 128'(mon_e.w));
                    chk("sb_last", 128'(m_last), 128'(mon_e.l));
                end
            end
            occ_model = occ_model + mon_fire - mon_pop;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        logic stale;
        int   fires;
        int   n_issued;
        int   n_simul;
        logic simul;
        logic [CW-1:0] occ_before;

        n_tests     = 0;
        n_fail      = 0;
        occ_model   = 0;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        m_ready     = 1'b0;
        issue_data  = 128'h0;

        vecs[0] = '{data: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                    exp_w: {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF},
                    stall_at: 4, stall_len: 0};
        vecs[1] = '{data: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                    exp_w: {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF},
                    stall_at: 1, stall_len: 5};
        vecs[2] = '{data: 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98,
                    exp_w: {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98},
                    stall_at: 3, stall_len: 2};
        vecs[3] = '{data: 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A,
                    exp_w: {32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h5A5A5A5A},
                    stall_at: 0, stall_len: 1};

        // Reset state
        repeat (3) tick();
        chk("rst_issue_ready", 128'(issue_ready), 128'(1));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_last", 128'(m_last), 128'(0));
        chk("rst_m_data", 128'(m_data), 128'(0));
        chk("rst_occupancy", 128'(occupancy), 128'(0));
        chk("rst_err_overflow", 128'(err_overflow), 128'(0));
        rst_n = 1'b1;

        // Table-driven single blocks: latency, word order, m_last and stall hold
        m_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            tick();
            issue_valid = 1'b1;
            issue_data  = vecs[v].data;
            tick();
            issue_valid = 1'b0;
            chk("t1_occ_after_issue", 128'(occupancy), 128'(1));
            early = 1'b0;
            for (int k = 1; k < PIPE_LAT; k++) begin
                tick();
                if (m_valid) early = 1'b1;
            end
            chk("t1_latency_early", 128'(early), 128'(0));
            tick();
            chk("t1_valid_at_latency", 128'(m_valid), 128'(1));
            for (int w = 0; w < 4; w++) begin
                if (w == vecs[v].stall_at) begin
                    m_ready = 1'b0;
                    for (int s = 0; s < vecs[v].stall_len; s++) begin
                        tick();
                        chk("t1_stall_data", 128'(m_data), 128'(vecs[v].exp_w[w]));
                        chk("t1_stall_valid", 128'(m_valid), 128'(1));
                    end
                    m_ready = 1'b1;
                end
                chk("t1_word", 128'(m_data), 128'(vecs[v].exp_w[w]));
                chk("t1_last", 128'(m_last), 128'(w == 3));
                tick();
            end
            chk("t1_empty_after", 128'(m_valid), 128'(0));
            chk("t1_occ_after", 128'(occupancy), 128'(0));
        end

        // Credit limit with the sink stalled
        tick();
        m_ready     = 1'b0;
        issue_valid = 1'b1;
        fires       = 0;
        for (int k = 0; k < 8; k++) begin
            if (issue_ready) fires++;
            tick();
        end
        issue_valid = 1'b0;
        chk("t2_fire_count", 128'(fires), 128'(DEPTH));
        chk("t2_issue_ready_low", 128'(issue_ready), 128'(0));
        chk("t2_occupancy_full", 128'(occupancy), 128'(DEPTH));
        repeat (PIPE_LAT) tick();
        chk("t2_m_valid", 128'(m_valid), 128'(1));
        chk("t2_occupancy_hold", 128'(occupancy), 128'(DEPTH));
        chk("t2_no_overflow", 128'(err_overflow), 128'(0));
        chk("t2_head_word", 128'(m_data), 128'(sb[0].w));

        // Random traffic from full: simultaneous issue/pop and pointer wrap over many blocks
        n_issued = 0;
        n_simul  = 0;
        for (int k = 0; k < 200; k++) begin
            issue_valid = ($urandom_range(0, 4) == 0);
            m_ready     = ($urandom_range(0, 3) != 0);
            simul       = issue_valid && issue_ready && m_valid && m_ready && m_last;
            occ_before  = occupancy;
            if (issue_valid && issue_ready) n_issued++;
            tick();
            if (simul) begin
                n_simul++;
                chk("t3_occ_hold_on_issue_and_pop", 128'(occupancy), 128'(occ_before));
            end
        end
        issue_valid = 1'b0;
        chk("t3_blocks_issued", 128'(n_issued >= 10), 128'(1));
        chk("t3_simul_seen", 128'(n_simul > 0), 128'(1));
        drain("t3_drain_timeout", 300);
        chk("t3_sb_empty", 128'(sb.size()), 128'(0));

        // Forced overflow: pulse the tap with the FIFO full
        m_ready     = 1'b0;
        issue_valid = 1'b1;
        repeat (DEPTH) tick();
        issue_valid = 1'b0;
        chk("t4_occupancy_full", 128'(occupancy), 128'(DEPTH));
        repeat (PIPE_LAT) tick();
        chk("t4_m_valid", 128'(m_valid), 128'(1));
        chk("t4_err_before", 128'(err_overflow), 128'(0));
        force dut.tap_s = 1'b1;
        tick();
        release dut.tap_s;
        chk("t4_err_set", 128'(err_overflow), 128'(1));
        chk("t4_occupancy", 128'(occupancy), 128'(DEPTH));
        chk("t4_head_kept", 128'(m_data), 128'(sb[0].w));
        repeat (3) tick();
        chk("t4_err_sticky", 128'(err_overflow), 128'(1));
        drain("t4_drain_timeout", 100);
        chk("t4_sb_empty", 128'(sb.size()), 128'(0));
        chk("t4_err_after_drain", 128'(err_overflow), 128'(1));

        // Reset mid-flight: two blocks buffered, two still in the core
        m_ready     = 1'b0;
        issue_valid = 1'b1;
        repeat (2) tick();
        issue_valid = 1'b0;
        repeat (PIPE_LAT) tick();
        issue_valid = 1'b1;
        repeat (2) tick();
        issue_valid = 1'b0;
        chk("t5_occupancy_before", 128'(occupancy), 128'(DEPTH));
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m_valid", 128'(m_valid), 128'(0));
        chk("t5_rst_occupancy", 128'(occupancy), 128'(0));
        chk("t5_rst_issue_ready", 128'(issue_ready), 128'(1));
        sb.delete();
        occ_model = 0;
        tick();
        rst_n   = 1'b1;
        m_ready = 1'b1;
        stale   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (m_valid) stale = 1'b1;
        end
        chk("t5_no_stale_output", 128'(stale), 128'(0));
        chk("t5_err_cleared", 128'(err_overflow), 128'(0));
        chk("t5_occupancy_after", 128'(occupancy), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
